// File: rtl/traffic_phase_sequencer.sv
// N-phase round-robin intersection sequencer: min/max green, yellow, all-red, walk, BCD countdown.
// Optional emergency preemption is compiled in when PREEMPT_EN is defined.
module traffic_phase_sequencer #(
  parameter int unsigned NUM_PHASES   = 4,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned GREEN_MIN    = 10,
  parameter int unsigned GREEN_MAX    = 30,
  parameter int unsigned YELLOW_TIME  = 4,
  parameter int unsigned ALL_RED_TIME = 2,
  parameter int unsigned WALK_TIME    = 7,
  localparam int unsigned PW = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PHASES-1:0] car_sensor,
  input  logic [NUM_PHASES-1:0] ped_button,
`ifdef PREEMPT_EN
  input  logic                  preempt_req,
  input  logic [PW-1:0]         preempt_phase,
  output logic                  preempt_active,
`endif
  output logic [NUM_PHASES-1:0] green,
  output logic [NUM_PHASES-1:0] yellow,
  output logic [NUM_PHASES-1:0] red,
  output logic [NUM_PHASES-1:0] walk,
  output logic [NUM_PHASES-1:0] hand,
  output logic [PW-1:0]         active_phase,
  output logic [3:0]            cd_tens,
  output logic [3:0]            cd_ones
);

  localparam int unsigned TMAX = (GREEN_MAX > YELLOW_TIME)
                                 ? ((GREEN_MAX > ALL_RED_TIME) ? GREEN_MAX : ALL_RED_TIME)
                                 : ((YELLOW_TIME > ALL_RED_TIME) ? YELLOW_TIME : ALL_RED_TIME);
  localparam int unsigned TW     = $clog2(TMAX + 1);
  localparam int unsigned SW     = $clog2(TICK_DIV + 1);
  localparam int unsigned RST_CD = (ALL_RED_TIME > 99) ? 99 : ALL_RED_TIME;

  typedef enum logic [1:0] {
    ST_ALL_RED,
    ST_GREEN,
    ST_YELLOW
  } state_t;

  state_t                r_state, w_state;
  logic [PW-1:0]         r_active, w_active, w_sel;
  logic [TW-1:0]         r_timer, w_timer;
  logic [TW-1:0]         r_elapsed, w_elapsed, w_elapsed_inc, w_cd_bin;
  logic [SW-1:0]         r_prescale;
  logic                  w_tick;
  logic [NUM_PHASES-1:0] r_car_pend, w_car_pend, r_ped_pend, w_ped_pend;
  logic [NUM_PHASES-1:0] w_demand, w_other, w_onehot, w_onehot_n, w_walk;
  logic                  r_walk_req, w_walk_req;
  logic                  w_leave, w_hold;
  logic                  w_pre_req;
  logic [PW-1:0]         w_pre_phase;
  logic [6:0]            w_cd_sat;
  logic [NUM_PHASES-1:0] r_green, r_yellow, r_red, r_walk, r_hand;
  logic [3:0]            r_cd_tens, r_cd_ones;

`ifdef PREEMPT_EN
  logic r_pre_active;

  assign w_pre_req      = preempt_req;
  assign w_pre_phase    = preempt_phase;
  assign preempt_active = r_pre_active;

  always_ff @(posedge clk) begin
    if (!rst_n) r_pre_active <= 1'b0;
    else        r_pre_active <= (w_state == ST_GREEN) && w_pre_req && (w_active == w_pre_phase);
  end
`else
  assign w_pre_req   = 1'b0;
  assign w_pre_phase = '0;
`endif

  assign w_tick     = (r_prescale == SW'(TICK_DIV - 1));
  assign w_demand   = r_car_pend | r_ped_pend | car_sensor | ped_button;
  assign w_onehot   = NUM_PHASES'(1) << r_active;
  assign w_other    = w_demand & ~w_onehot;
  assign w_onehot_n = NUM_PHASES'(1) << w_active;

  // Scan from active+N down to active+1 so the nearest successor wins; active itself is last resort.
  always_comb begin
    int unsigned idx;
    w_sel = '0;
    for (int unsigned k = NUM_PHASES; k >= 1; k--) begin
      idx = (32'(r_active) + k) % NUM_PHASES;
      if (w_demand[PW'(idx)]) w_sel = PW'(idx);
    end
  end

  always_comb begin
    w_state       = r_state;
    w_active      = r_active;
    w_timer       = r_timer;
    w_elapsed     = r_elapsed;
    w_walk_req    = r_walk_req;
    w_car_pend    = r_car_pend | car_sensor;
    w_ped_pend    = r_ped_pend | ped_button;
    w_elapsed_inc = (r_elapsed >= TW'(GREEN_MAX)) ? r_elapsed : r_elapsed + 1'b1;
    w_hold        = w_pre_req && (w_pre_phase == r_active);
    w_leave       = 1'b0;
    unique case (r_state)
      ST_ALL_RED: begin
        if (w_tick) begin
          if (r_timer <= TW'(1)) begin
            w_state              = ST_GREEN;
            w_active             = w_pre_req ? w_pre_phase : w_sel;
            w_elapsed            = '0;
            w_walk_req           = w_ped_pend[w_active];
            w_car_pend[w_active] = 1'b0;
            w_ped_pend[w_active] = 1'b0;
          end else begin
            w_timer = r_timer - 1'b1;
          end
        end
      end
      ST_GREEN: begin
        w_car_pend[r_active] = 1'b0;
        w_ped_pend[r_active] = 1'b0;
        if (w_tick) begin
          w_elapsed = w_elapsed_inc;
          w_leave   = (w_elapsed_inc >= TW'(GREEN_MIN)) && (|w_other) &&
                      (!car_sensor[r_active] || (w_elapsed_inc >= TW'(GREEN_MAX)));
        end
        // A held preempt phase parks at GREEN_MIN so normal rules resume cleanly on release.
        if (w_hold) begin
          w_leave   = 1'b0;
          w_elapsed = TW'(GREEN_MIN);
        end else if (w_pre_req && w_tick) begin
          w_leave = 1'b1;
        end
        if (w_leave) begin
          w_state    = ST_YELLOW;
          w_timer    = TW'(YELLOW_TIME);
          w_walk_req = 1'b0;
        end
      end
      ST_YELLOW: begin
        if (w_tick) begin
          if (r_timer <= TW'(1)) begin
            w_state = ST_ALL_RED;
            w_timer = TW'(ALL_RED_TIME);
          end else begin
            w_timer = r_timer - 1'b1;
          end
        end
      end
      default: w_state = ST_ALL_RED;
    endcase
  end

  always_comb begin
    w_walk = '0;
    if ((w_state == ST_GREEN) && w_walk_req && (w_elapsed < TW'(WALK_TIME)) && !w_pre_req)
      w_walk = w_onehot_n;
    w_cd_bin = w_timer;
    if (w_state == ST_GREEN)
      w_cd_bin = (w_elapsed < TW'(GREEN_MIN)) ? TW'(GREEN_MIN) - w_elapsed : '0;
    w_cd_sat = (32'(w_cd_bin) > 32'd99) ? 7'd99 : 7'(w_cd_bin);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_ALL_RED;
      r_active   <= '0;
      r_timer    <= TW'(ALL_RED_TIME);
      r_elapsed  <= '0;
      r_prescale <= '0;
      r_car_pend <= '0;
      r_ped_pend <= '0;
      r_walk_req <= 1'b0;
      r_green    <= '0;
      r_yellow   <= '0;
      r_red      <= '1;
      r_walk     <= '0;
      r_hand     <= '1;
      r_cd_tens  <= 4'(RST_CD / 10);
      r_cd_ones  <= 4'(RST_CD % 10);
    end else begin
      r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
      r_state    <= w_state;
      r_active   <= w_active;
      r_timer    <= w_timer;
      r_elapsed  <= w_elapsed;
      r_car_pend <= w_car_pend;
      r_ped_pend <= w_ped_pend;
      r_walk_req <= w_walk_req;
      r_green    <= (w_state == ST_GREEN)  ? w_onehot_n : '0;
      r_yellow   <= (w_state == ST_YELLOW) ? w_onehot_n : '0;
      r_red      <= (w_state == ST_ALL_RED) ? '1 : ~w_onehot_n;
      r_walk     <= w_walk;
      r_hand     <= ~w_walk;
      r_cd_tens  <= 4'(w_cd_sat / 7'd10);
      r_cd_ones  <= 4'(w_cd_sat % 7'd10);
    end
  end

  assign green        = r_green;
  assign yellow       = r_yellow;
  assign red          = r_red;
  assign walk         = r_walk;
  assign hand         = r_hand;
  assign active_phase = r_active;
  assign cd_tens      = r_cd_tens;
  assign cd_ones      = r_cd_ones;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with short timing (TICK_DIV=2, one tick per 2 clocks).
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] car_sensor = '0;
  logic [3:0] ped_button = '0;
  logic [3:0] green, yellow, red, walk, hand;
  logic [1:0] active_phase;
  logic [3:0] cd_tens, cd_ones;
`ifdef PREEMPT_EN
  logic       preempt_req = 1'b0;
  logic [1:0] preempt_phase = '0;
  logic       preempt_active;
`endif

  int vectors = 0;
  int errors  = 0;

  traffic_phase_sequencer #(
    .NUM_PHASES  (4),
    .TICK_DIV    (2),
    .GREEN_MIN   (4),
    .GREEN_MAX   (8),
    .YELLOW_TIME (2),
    .ALL_RED_TIME(1),
    .WALK_TIME   (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .car_sensor    (car_sensor),
    .ped_button    (ped_button),
`ifdef PREEMPT_EN
    .preempt_req   (preempt_req),
    .preempt_phase (preempt_phase),
    .preempt_active(preempt_active),
`endif
    .green         (green),
    .yellow        (yellow),
    .red           (red),
    .walk          (walk),
    .hand          (hand),
    .active_phase  (active_phase),
    .cd_tens       (cd_tens),
    .cd_ones       (cd_ones)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Timeline after this returns: P1 no tick, P2 first tick -> phase selected, then ticks on even edges.
  task automatic reset_release;
    rst_n      = 1'b0;
    car_sensor = '0;
    ped_button = '0;
`ifdef PREEMPT_EN
    preempt_req   = 1'b0;
    preempt_phase = '0;
`endif
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_release();
    step(6);
    vectors++;
    if (green !== 4'b0001) begin
      errors++; $display("FAIL reset_pre_green got=%b exp=%b", green, 4'b0001);
    end
    rst_n = 1'b0;
    step(3);
    vectors++;
    if (red !== 4'b1111) begin
      errors++; $display("FAIL reset_red got=%b exp=%b", red, 4'b1111);
    end
    vectors++;
    if (hand !== 4'b1111) begin
      errors++; $display("FAIL reset_hand got=%b exp=%b", hand, 4'b1111);
    end
    vectors++;
    if ({green, yellow, walk} !== 12'h000) begin
      errors++; $display("FAIL reset_gyw got=%h exp=%h", {green, yellow, walk}, 12'h000);
    end
    vectors++;
    if (active_phase !== 2'd0) begin
      errors++; $display("FAIL reset_active got=%0d exp=0", active_phase);
    end
    vectors++;
    if ({cd_tens, cd_ones} !== 8'h01) begin
      errors++; $display("FAIL reset_cd got=%h exp=01", {cd_tens, cd_ones});
    end
  endtask

  task automatic test_rest_green;
    reset_release();
    step(1);
    vectors++;
    if (red !== 4'b1111) begin
      errors++; $display("FAIL rest_allred got=%b exp=1111", red);
    end
    step(1);
    vectors++;
    if ({green, yellow, red} !== 12'b0001_0000_1110) begin
      errors++; $display("FAIL rest_enter got=%b exp=%b", {green, yellow, red}, 12'b0001_0000_1110);
    end
    vectors++;
    if ({cd_tens, cd_ones} !== 8'h04) begin
      errors++; $display("FAIL rest_cd_start got=%h exp=04", {cd_tens, cd_ones});
    end
    step(6);
    vectors++;
    if ({cd_tens, cd_ones} !== 8'h01) begin
      errors++; $display("FAIL rest_cd_3ticks got=%h exp=01", {cd_tens, cd_ones});
    end
    step(2);
    vectors++;
    if ({cd_tens, cd_ones} !== 8'h00) begin
      errors++; $display("FAIL rest_cd_4ticks got=%h exp=00", {cd_tens, cd_ones});
    end
    for (int i = 0; i < 50; i++) begin
      step(2);
      vectors++;
      if ({green, yellow, red, cd_tens, cd_ones} !== 20'b0001_0000_1110_0000_0000) begin
        errors++; $display("FAIL rest_hold tick=%0d got=%b", i, {green, yellow, red, cd_tens, cd_ones});
      end
    end
  endtask

  task automatic test_skip_phase;
    reset_release();
    step(2);
    car_sensor = 4'b0100;
    step(2);
    car_sensor = 4'b0000;
    step(5);
    vectors++;
    if (green !== 4'b0001) begin
      errors++; $display("FAIL skip_min_green got=%b exp=0001", green);
    end
    step(1);
    vectors++;
    if ({green, yellow, red} !== 12'b0000_0001_1110) begin
      errors++; $display("FAIL skip_yellow got=%b exp=%b", {green, yellow, red}, 12'b0000_0001_1110);
    end
    vectors++;
    if ({cd_tens, cd_ones} !== 8'h02) begin
      errors++; $display("FAIL skip_cd_yellow got=%h exp=02", {cd_tens, cd_ones});
    end
    step(2);
    vectors++;
    if ({yellow, cd_tens, cd_ones} !== 12'b0001_0000_0001) begin
      errors++; $display("FAIL skip_yellow2 got=%b exp=%b", {yellow, cd_tens, cd_ones}, 12'b0001_0000_0001);
    end
    step(2);
    vectors++;
    if ({red, cd_tens, cd_ones} !== 12'b1111_0000_0001) begin
      errors++; $display("FAIL skip_allred got=%b exp=%b", {red, cd_tens, cd_ones}, 12'b1111_0000_0001);
    end
    step(2);
    vectors++;
    if ({green, red} !== 8'b0100_1011) begin
      errors++; $display("FAIL skip_ph2_green got=%b exp=%b", {green, red}, 8'b0100_1011);
    end
    vectors++;
    if (active_phase !== 2'd2) begin
      errors++; $display("FAIL skip_active got=%0d exp=2", active_phase);
    end
    vectors++;
    if ({cd_tens, cd_ones} !== 8'h04) begin
      errors++; $display("FAIL skip_cd_green got=%h exp=04", {cd_tens, cd_ones});
    end
  endtask

  task automatic test_max_green;
    reset_release();
    car_sensor = 4'b0001;
    step(2);
    vectors++;
    if (green !== 4'b0001) begin
      errors++; $display("FAIL max_enter got=%b exp=0001", green);
    end
    car_sensor = 4'b0011;
    step(2);
    car_sensor = 4'b0001;
    step(13);
    vectors++;
    if ({green, yellow, cd_tens, cd_ones} !== 16'b0001_0000_0000_0000) begin
      errors++; $display("FAIL max_ext got=%b", {green, yellow, cd_tens, cd_ones});
    end
    step(1);
    vectors++;
    if ({green, yellow} !== 8'b0000_0001) begin
      errors++; $display("FAIL max_yellow got=%b exp=%b", {green, yellow}, 8'b0000_0001);
    end
    car_sensor = 4'b0000;
    step(6);
    vectors++;
    if ({green, active_phase} !== 6'b0010_01) begin
      errors++; $display("FAIL max_next got=%b exp=%b", {green, active_phase}, 6'b0010_01);
    end
  endtask

  task automatic test_walk;
    reset_release();
    step(2);
    vectors++;
    if ({walk, hand} !== 8'b0000_1111) begin
      errors++; $display("FAIL walk_idle got=%b exp=%b", {walk, hand}, 8'b0000_1111);
    end
    ped_button = 4'b1000;
    step(1);
    ped_button = 4'b0000;
    step(7);
    vectors++;
    if (yellow !== 4'b0001) begin
      errors++; $display("FAIL walk_ph0_yellow got=%b exp=0001", yellow);
    end
    step(6);
    vectors++;
    if ({green, walk, hand} !== 12'b1000_1000_0111) begin
      errors++; $display("FAIL walk_start got=%b exp=%b", {green, walk, hand}, 12'b1000_1000_0111);
    end
    vectors++;
    if ({active_phase, cd_tens, cd_ones} !== 10'b11_0000_0100) begin
      errors++; $display("FAIL walk_active_cd got=%b exp=%b", {active_phase, cd_tens, cd_ones}, 10'b11_0000_0100);
    end
    step(5);
    vectors++;
    if ({walk, hand} !== 8'b1000_0111) begin
      errors++; $display("FAIL walk_last got=%b exp=%b", {walk, hand}, 8'b1000_0111);
    end
    step(1);
    vectors++;
    if ({green, walk, hand} !== 12'b1000_0000_1111) begin
      errors++; $display("FAIL walk_end got=%b exp=%b", {green, walk, hand}, 12'b1000_0000_1111);
    end
  endtask

`ifdef PREEMPT_EN
  task automatic test_preempt;
    reset_release();
    step(4);
    preempt_req   = 1'b1;
    preempt_phase = 2'd2;
    step(1);
    vectors++;
    if (green !== 4'b0001) begin
      errors++; $display("FAIL pre_wait got=%b exp=0001", green);
    end
    step(1);
    vectors++;
    if ({green, yellow} !== 8'b0000_0001) begin
      errors++; $display("FAIL pre_yellow got=%b exp=%b", {green, yellow}, 8'b0000_0001);
    end
    step(6);
    vectors++;
    if ({green, preempt_active} !== 5'b0100_1) begin
      errors++; $display("FAIL pre_hold got=%b exp=%b", {green, preempt_active}, 5'b0100_1);
    end
    car_sensor = 4'b0001;
    step(20);
    vectors++;
    if ({green, preempt_active} !== 5'b0100_1) begin
      errors++; $display("FAIL pre_held got=%b exp=%b", {green, preempt_active}, 5'b0100_1);
    end
    preempt_req = 1'b0;
    step(1);
    vectors++;
    if ({green, preempt_active} !== 5'b0100_0) begin
      errors++; $display("FAIL pre_release got=%b exp=%b", {green, preempt_active}, 5'b0100_0);
    end
    step(1);
    vectors++;
    if (yellow !== 4'b0100) begin
      errors++; $display("FAIL pre_resume got=%b exp=0100", yellow);
    end
    car_sensor = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_rest_green();
    test_skip_phase();
    test_max_green();
    test_walk();
`ifdef PREEMPT_EN
    test_preempt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
